vga_fb_reader: RTL and testbench

- Pixel-side consumer of the VGA sync generator's outputs. Turns pixel_x/pixel_y/display_on into read addresses for a 160x120, 3-bit-colour framebuffer RAM (synchronous read, 1-cycle latency).
- Drives the 4-bit RGB outputs, with a 4x4 robot-position cursor overlaid on top of the framebuffer image.
- Delays h_sync/v_sync so they stay aligned with the RGB outputs at the VGA connector.

---
 rtl/vga_fb_if.sv | 31 +++
 rtl/vga_fb_reader.sv | 114 +++++++++++
 tb/tb_vga_fb_reader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_if.sv
// Pixel-side bundle between the sync generator, framebuffer RAM and the VGA connector.
// The reader uses the slave view; whoever drives pixels and the RAM uses master.
interface vga_fb_if;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        display_on;
  logic        h_sync;
  logic        v_sync;
  logic [7:0]  cursor_x;
  logic [6:0]  cursor_y;
  logic [14:0] fb_raddr;
  logic        fb_ren;
  logic [2:0]  fb_rdata;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        frame_tick;
  logic [7:0]  frame_count;

  modport slave (
    input  pixel_x, pixel_y, display_on, h_sync, v_sync, cursor_x, cursor_y, fb_rdata,
    output fb_raddr, fb_ren, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_tick, frame_count
  );

  modport master (
    output pixel_x, pixel_y, display_on, h_sync, v_sync, cursor_x, cursor_y, fb_rdata,
    input  fb_raddr, fb_ren, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_tick, frame_count
  );
endinterface

// File: rtl/vga_fb_reader.sv
// Two-stage pixel pipeline: framebuffer address + cursor hit, then RGB with cursor overlay.
// Syncs ride the same two registers so they never skew against the colour.
module vga_fb_reader #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int CUR_SIZE    = 4,
  parameter int VA_END      = 480
) (
  input  logic     clock_25,
  input  logic     reset,
  vga_fb_if.slave  bus
);

  logic [9:0]  w_cx;
  logic [9:0]  w_cy;
  logic [14:0] w_addr;
  logic [9:0]  w_cur_x_end;
  logic [9:0]  w_cur_y_end;
  logic        w_hit;
  logic        w_bdry;

  logic [14:0] r_fb_raddr;
  logic        r_fb_ren;
  logic        r_act1;
  logic        r_hit1;
  logic        r_hs1;
  logic        r_vs1;
  logic [3:0]  r_r;
  logic [3:0]  r_g;
  logic [3:0]  r_b;
  logic        r_hs2;
  logic        r_vs2;
  logic [7:0]  r_cur_x_l;
  logic [6:0]  r_cur_y_l;
  logic        r_frame_tick;
  logic [7:0]  r_frame_count;

  assign w_cx   = bus.pixel_x >> SCALE_SHIFT;
  assign w_cy   = bus.pixel_y >> SCALE_SHIFT;
  assign w_addr = 15'(w_cy) * 15'(FB_W) + 15'(w_cx);

  // Widened end points so a cursor near the right/bottom edge clips instead of wrapping.
  assign w_cur_x_end = {2'b00, r_cur_x_l} + 10'(CUR_SIZE);
  assign w_cur_y_end = {3'b000, r_cur_y_l} + 10'(CUR_SIZE);

  assign w_hit = bus.display_on
              && (w_cx >= {2'b00, r_cur_x_l})  && (w_cx < w_cur_x_end) && (w_cx < 10'(FB_W))
              && (w_cy >= {3'b000, r_cur_y_l}) && (w_cy < w_cur_y_end) && (w_cy < 10'(FB_H));

  assign w_bdry = (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'(VA_END));

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      r_fb_raddr    <= '0;
      r_fb_ren      <= 1'b0;
      r_act1        <= 1'b0;
      r_hit1        <= 1'b0;
      r_hs1         <= 1'b1;
      r_vs1         <= 1'b1;
      r_r           <= '0;
      r_g           <= '0;
      r_b           <= '0;
      r_hs2         <= 1'b1;
      r_vs2         <= 1'b1;
      r_cur_x_l     <= '0;
      r_cur_y_l     <= '0;
      r_frame_tick  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_fb_raddr <= bus.display_on ? w_addr : 15'd0;
      r_fb_ren   <= bus.display_on;
      r_act1     <= bus.display_on;
      r_hit1     <= w_hit;
      r_hs1      <= bus.h_sync;
      r_vs1      <= bus.v_sync;

      // RAM data arriving now belongs to the pixel captured in stage 1.
      if (!r_act1) begin
        r_r <= 4'h0;
        r_g <= 4'h0;
        r_b <= 4'h0;
      end else if (r_hit1) begin
        r_r <= 4'hF;
        r_g <= 4'hF;
        r_b <= 4'h0;
      end else begin
        r_r <= {4{bus.fb_rdata[2]}};
        r_g <= {4{bus.fb_rdata[1]}};
        r_b <= {4{bus.fb_rdata[0]}};
      end
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;

      r_frame_tick <= w_bdry;
      if (w_bdry) begin
        r_cur_x_l     <= bus.cursor_x;
        r_cur_y_l     <= bus.cursor_y;
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign bus.fb_raddr    = r_fb_raddr;
  assign bus.fb_ren      = r_fb_ren;
  assign bus.vga_r       = r_r;
  assign bus.vga_g       = r_g;
  assign bus.vga_b       = r_b;
  assign bus.vga_hs      = r_hs2;
  assign bus.vga_vs      = r_vs2;
  assign bus.frame_tick  = r_frame_tick;
  assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader: reset, addressing, cursor overlay, frame counter, sync alignment.
module tb_vga_fb_reader;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   exp_fc;

  vga_fb_if bus ();

  vga_fb_reader dut (
    .clock_25 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int x, input int y, input logic de);
    bus.pixel_x    = 10'(x);
    bus.pixel_y    = 10'(y);
    bus.display_on = de;
  endtask

  // Pixel goes in at edge k, RAM data is presented before edge k+1, RGB checked after it.
  task automatic px_check(input string tag, input int x, input int y,
                          input logic [2:0] rd, input logic [11:0] exp_rgb);
    set_px(x, y, 1'b1);
    tick();
    bus.fb_rdata = rd;
    tick();
    chk(tag, 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(exp_rgb));
  endtask

  task automatic boundary(input logic [7:0] cx, input logic [6:0] cy);
    bus.cursor_x = cx;
    bus.cursor_y = cy;
    set_px(0, 480, 1'b0);
    tick();
    exp_fc = (exp_fc + 1) % 256;
    set_px(1, 480, 1'b0);
  endtask

  logic hs_pat [10];
  logic vs_pat [10];
  logic de_pat [10];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_fc   = 0;
    rst      = 1'b1;
    bus.pixel_x    = 10'd300;
    bus.pixel_y    = 10'd100;
    bus.display_on = 1'b1;
    bus.h_sync     = 1'b0;
    bus.v_sync     = 1'b0;
    bus.cursor_x   = 8'd7;
    bus.cursor_y   = 7'd3;
    bus.fb_rdata   = 3'b111;

    // Reset held with active-looking inputs
    repeat (5) tick();
    chk("rst_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h0);
    chk("rst_hs", 32'(bus.vga_hs), 32'd1);
    chk("rst_vs", 32'(bus.vga_vs), 32'd1);
    chk("rst_ren", 32'(bus.fb_ren), 32'd0);
    chk("rst_fc", 32'(bus.frame_count), 32'd0);
    chk("rst_tick", 32'(bus.frame_tick), 32'd0);
    rst = 1'b0;
    tick();
    chk("rel1_hs", 32'(bus.vga_hs), 32'd1);
    chk("rel1_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h0);
    chk("rel1_ren", 32'(bus.fb_ren), 32'd1);
    tick();
    chk("rel2_hs", 32'(bus.vga_hs), 32'd0);
    chk("rel2_vs", 32'(bus.vga_vs), 32'd0);
    bus.h_sync = 1'b1;
    bus.v_sync = 1'b1;

    // Park the cursor away from the addressing tests
    boundary(8'd100, 7'd100);
    chk("bdry_tick", 32'(bus.frame_tick), 32'd1);
    chk("bdry_fc", 32'(bus.frame_count), 32'(exp_fc));
    tick();
    chk("bdry_tick_low", 32'(bus.frame_tick), 32'd0);

    // Addressing
    set_px(13, 9, 1'b1);
    tick();
    chk("addr_13_9", 32'(bus.fb_raddr), 32'd323);
    chk("ren_13_9", 32'(bus.fb_ren), 32'd1);
    bus.fb_rdata = 3'b101;
    tick();
    chk("rgb_13_9", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'hF0F);
    set_px(639, 479, 1'b1);
    tick();
    chk("addr_max", 32'(bus.fb_raddr), 32'd19199);
    set_px(700, 10, 1'b0);
    tick();
    chk("addr_blank", 32'(bus.fb_raddr), 32'd0);
    chk("ren_blank", 32'(bus.fb_ren), 32'd0);
    tick();
    chk("rgb_blank", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h0);
    px_check("rgb_010", 200, 300, 3'b010, 12'h0F0);

    // Cursor at cell (10,5): pixels 40..55 x 20..35
    boundary(8'd10, 7'd5);
    px_check("cur_tl", 40, 20, 3'b001, 12'hFF0);
    px_check("cur_br", 55, 35, 3'b001, 12'hFF0);
    px_check("cur_mid", 47, 28, 3'b111, 12'hFF0);
    px_check("cur_right_out", 56, 20, 3'b001, 12'h00F);
    px_check("cur_left_out", 39, 20, 3'b100, 12'hF00);
    px_check("cur_below_out", 40, 36, 3'b001, 12'h00F);

    // Mid-frame change is deferred to the next boundary
    bus.cursor_x = 8'd20;
    px_check("mid_hold_old", 40, 200, 3'b001, 12'h00F);
    px_check("mid_hold_old2", 40, 20, 3'b001, 12'hFF0);
    boundary(8'd20, 7'd5);
    px_check("mid_moved_old", 40, 20, 3'b001, 12'h00F);
    px_check("mid_moved_new", 80, 20, 3'b001, 12'hFF0);

    // Right-edge clipping, no wrap to column 0
    boundary(8'd158, 7'd5);
    px_check("clip_158", 632, 20, 3'b001, 12'hFF0);
    px_check("clip_159", 639, 20, 3'b001, 12'hFF0);
    px_check("clip_nowrap0", 0, 20, 3'b001, 12'h00F);
    px_check("clip_nowrap1", 4, 20, 3'b001, 12'h00F);

    // Sync/RGB alignment: output after edge i reflects inputs sampled at edge i-1
    hs_pat = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 1};
    vs_pat = '{1, 1, 0, 0, 1, 0, 1, 1, 0, 1};
    de_pat = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1};
    bus.fb_rdata = 3'b111;
    for (int i = 0; i < 10; i++) begin
      set_px(400, 400, de_pat[i]);
      bus.h_sync = hs_pat[i];
      bus.v_sync = vs_pat[i];
      tick();
      if (i > 0) begin
        chk($sformatf("sync_hs_%0d", i), 32'(bus.vga_hs), 32'(hs_pat[i-1]));
        chk($sformatf("sync_vs_%0d", i), 32'(bus.vga_vs), 32'(vs_pat[i-1]));
        chk($sformatf("sync_rgb_%0d", i), 32'({bus.vga_r, bus.vga_g, bus.vga_b}),
            de_pat[i-1] ? 32'hFFF : 32'h0);
      end
    end
    bus.h_sync = 1'b1;
    bus.v_sync = 1'b1;

    // Frame counter wrap after 256 boundaries in total
    chk("fc_before_wrap", 32'(bus.frame_count), 32'(exp_fc));
    while (exp_fc != 0) begin
      boundary(8'd158, 7'd5);
      tick();
    end
    chk("fc_wrap", 32'(bus.frame_count), 32'd0);

    // Reset mid-frame
    set_px(100, 100, 1'b1);
    bus.h_sync = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h0);
    chk("midrst_hs", 32'(bus.vga_hs), 32'd1);
    chk("midrst_addr", 32'(bus.fb_raddr), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_rel1_hs", 32'(bus.vga_hs), 32'd1);
    tick();
    chk("midrst_rel2_hs", 32'(bus.vga_hs), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
